// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB plus a PHT of saturating counters, in either bimodal
// (GHR_W = 0) or gshare (GHR_W > 0) mode, with speculative global history and repair.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   lookup_valid, lookup_pc    fetch-stage query
//   pred_hit, pred_taken       combinational prediction for lookup_pc
//   pred_target                predicted next pc (BTB target or lookup_pc + 4)
//   pred_ghr                   history snapshot to carry down the pipe
//   upd_valid, upd_pc, ...     EX-stage resolution: outcome, target, mispredict flag,
//                              and the history snapshot the branch was predicted with
//   branch_cnt, mispredict_cnt saturating statistics counters
module branch_predictor #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned IDX_W = 6,
   parameter int unsigned CNT_W = 2,
   parameter int unsigned GHR_W = 0,
   parameter int unsigned TAG_W = 8,
   localparam int unsigned GW   = (GHR_W == 0) ? 1 : GHR_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lookup_valid,
   input  logic [PC_W-1:0] lookup_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   output logic [GW-1:0]   pred_ghr,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_mispredict,
   input  logic [GW-1:0]   upd_ghr,
   output logic [31:0]     branch_cnt,
   output logic [31:0]     mispredict_cnt
);

   localparam int unsigned      DEPTH   = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   // Weakly-not-taken: 2^(CNT_W-1)-1, i.e. all ones below the MSB.
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_MAX >> 1;

   logic                 btb_valid_q  [DEPTH];
   logic [TAG_W-1:0]     btb_tag_q    [DEPTH];
   logic [PC_W-1:0]      btb_target_q [DEPTH];
   logic [CNT_W-1:0]     pht_q        [DEPTH];
   logic [GW-1:0]        ghr_q, ghr_d;
   logic [31:0]          branch_cnt_q, mispredict_cnt_q;

   logic [IDX_W-1:0]     lk_bidx, lk_pidx, up_bidx, up_pidx;
   logic [TAG_W-1:0]     lk_tag, up_tag;
   logic [CNT_W-1:0]     cnt_cur, cnt_nxt;

   // Bimodal ignores history entirely so upd_ghr cannot perturb the index.
   function automatic logic [IDX_W-1:0] pht_index(input logic [PC_W-1:0] pc,
                                                  input logic [GW-1:0]   ghr);
      if (GHR_W == 0) return pc[IDX_W+1:2];
      return pc[IDX_W+1:2] ^ IDX_W'(ghr);
   endfunction

   assign lk_bidx = lookup_pc[IDX_W+1:2];
   assign lk_tag  = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign lk_pidx = pht_index(lookup_pc, ghr_q);
   assign up_bidx = upd_pc[IDX_W+1:2];
   assign up_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign up_pidx = pht_index(upd_pc, upd_ghr);

   // Prediction reads registered state only, so same-cycle updates are not bypassed.
   assign pred_hit    = btb_valid_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
   assign pred_taken  = pred_hit && pht_q[lk_pidx][CNT_W-1];
   assign pred_target = pred_taken ? btb_target_q[lk_bidx] : lookup_pc + PC_W'(4);
   assign pred_ghr    = ghr_q;

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

   assign cnt_cur = pht_q[up_pidx];

   always_comb begin
      cnt_nxt = cnt_cur;
      if (upd_taken) begin
         if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_W'(1);
      end else if (cnt_cur != '0) begin
         cnt_nxt = cnt_cur - CNT_W'(1);
      end
   end

   // Repair from a resolved mispredict takes priority over the speculative shift.
   always_comb begin
      ghr_d = ghr_q;
      if (GHR_W == 0) begin
         ghr_d = '0;
      end else if (upd_valid && upd_mispredict) begin
         ghr_d = GW'({upd_ghr, upd_taken});
      end else if (lookup_valid && pred_hit) begin
         ghr_d = GW'({ghr_q, pred_taken});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            btb_valid_q[i] <= 1'b0;
            pht_q[i]       <= CNT_WNT;
         end
         ghr_q            <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         ghr_q <= ghr_d;
         if (upd_valid) begin
            pht_q[up_pidx] <= cnt_nxt;
            if (upd_taken) btb_valid_q[up_bidx] <= 1'b1;
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (upd_mispredict && (mispredict_cnt_q != '1)) begin
               mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
         end
      end
   end

   // Tag/target need no reset: they are only observed through a set valid bit.
   always_ff @(posedge clk) begin
      if (!rst && upd_valid && upd_taken) begin
         btb_tag_q[up_bidx]    <= up_tag;
         btb_target_q[up_bidx] <= upd_target;
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{upd_pc[1:0], upd_pc[PC_W-1:IDX_W+TAG_W+2]};

endmodule
